lc_trans_sequencer: RTL and testbench

LC_TRANS_SEQUENCER -- requirements
Module: lc_trans_sequencer

---
 rtl/lc_trans_sequencer.sv | 155 +++++++++++++++
 tb/tb_lc_trans_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lc_trans_sequencer.sv
// Arbitrates software/JTAG lifecycle transition requests, checks legality, issues
// a single transition command to the LC FSM and reports completion, failure or timeout.
module lc_trans_sequencer #(
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic [2:0] req_target0,
  input  logic [2:0] req_target1,
  output logic [1:0] req_ready,
  output logic [1:0] resp_valid,
  output logic [1:0] resp_status,
  input  logic [2:0] cur_state,
  output logic       trans_cmd,
  output logic [2:0] trans_target,
  input  logic       trans_done,
  input  logic       trans_ok,
  output logic       busy,
  output logic       locked,
  output logic [1:0] fail_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_CMD   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] STS_OK      = 2'b00;
  localparam logic [1:0] STS_ILLEGAL = 2'b01;
  localparam logic [1:0] STS_FAIL    = 2'b10;
  localparam logic [1:0] STS_TIMEOUT = 2'b11;

  localparam logic [2:0] LC_RAW = 3'd0;
  localparam logic [2:0] LC_TU0 = 3'd1;
  localparam logic [2:0] LC_TL0 = 3'd2;
  localparam logic [2:0] LC_RMA = 3'd3;

  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);
  localparam logic [1:0] FAIL_LIMIT = 2'(MAX_FAIL);

  state_t     state_q, state_d;
  logic       rr_q, rr_d;
  logic       grant_q, grant_d;
  logic [2:0] target_q, target_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] status_q, status_d;
  logic [1:0] fail_q, fail_d;
  logic       locked_q, locked_d;
  logic [1:0] ready_c;
  logic       gsel;

  function automatic logic is_legal(input logic [2:0] from, input logic [2:0] to);
    is_legal = ((from == LC_RAW) && (to == LC_TU0)) ||
               ((from == LC_TU0) && (to == LC_TL0)) ||
               ((from == LC_TL0) && (to == LC_TU0)) ||
               ((from == LC_TU0) && (to == LC_RMA)) ||
               ((from == LC_TL0) && (to == LC_RMA));
  endfunction

  // Round-robin: the favoured requester wins if valid, otherwise the other one.
  always_comb begin
    if (rr_q == 1'b0) gsel = req_valid[0] ? 1'b0 : 1'b1;
    else              gsel = req_valid[1] ? 1'b1 : 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    target_d = target_q;
    timer_d  = timer_q;
    status_d = status_q;
    fail_d   = fail_q;
    locked_d = locked_q | (fail_q >= FAIL_LIMIT);
    ready_c  = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          ready_c[gsel] = 1'b1;
          grant_d       = gsel;
          target_d      = gsel ? req_target1 : req_target0;
          rr_d          = ~gsel;
          status_d      = STS_OK;
          state_d       = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (is_legal(cur_state, target_q) && !locked_q) begin
          state_d = ST_CMD;
        end else begin
          status_d = STS_ILLEGAL;
          state_d  = ST_RESP;
        end
      end
      ST_CMD: begin
        timer_d = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 8'd1;
        // Completion wins over a timeout landing in the same cycle.
        if (trans_done) begin
          status_d = trans_ok ? STS_OK : STS_FAIL;
          state_d  = ST_RESP;
        end else if (timer_q == TMO_LAST) begin
          status_d = STS_TIMEOUT;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if ((status_q != STS_OK) && (fail_q != 2'd3)) fail_d = fail_q + 2'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      grant_q  <= 1'b0;
      target_q <= 3'd0;
      timer_q  <= 8'd0;
      status_q <= STS_OK;
      fail_q   <= 2'd0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      status_q <= status_d;
      fail_q   <= fail_d;
      locked_q <= locked_d;
    end
  end

  // The accept pulse is combinational, so it is gated to stay quiet during reset.
  assign req_ready    = ready_c & {2{rst_n}};
  assign resp_valid   = (state_q == ST_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_status  = status_q;
  assign trans_cmd    = (state_q == ST_CMD);
  assign trans_target = target_q;
  assign busy         = (state_q != ST_IDLE);
  assign locked       = locked_q;
  assign fail_cnt     = fail_q;

endmodule

// File: tb/tb_lc_trans_sequencer.sv
// Scoreboard bench for lc_trans_sequencer: directed requests push expected
// responses; a monitor checks each resp_valid pulse against the queue.
module tb_lc_trans_sequencer;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [2:0] req_target0 = 3'd0, req_target1 = 3'd0;
  logic [1:0] req_ready, resp_valid, resp_status, fail_cnt;
  logic [2:0] cur_state = 3'd0;
  logic       trans_cmd, trans_done = 1'b0, trans_ok = 1'b0;
  logic [2:0] trans_target;
  logic       busy, locked;

  lc_trans_sequencer #(.TIMEOUT_CYC(T), .MAX_FAIL(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_target0(req_target0), .req_target1(req_target1),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_status(resp_status),
    .cur_state(cur_state), .trans_cmd(trans_cmd), .trans_target(trans_target),
    .trans_done(trans_done), .trans_ok(trans_ok), .busy(busy),
    .locked(locked), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] who;
    logic [1:0] st;
    logic       cmd;
    logic [2:0] tgt;
    logic [7:0] lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0, cmd_cyc = 0, cmd_cnt = 0;
  logic [2:0] cmd_tgt = 3'd0;
  logic [1:0] last_ready = 2'b00;
  int lc_delay = 0;
  logic lc_ok = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: tracks commands and accepts, compares every response.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cmd_cnt = 0;
    end else begin
      if (req_ready != 2'b00) last_ready = req_ready;
      if (trans_cmd) begin
        cmd_cnt++;
        cmd_cyc = cyc;
        cmd_tgt = trans_target;
      end
      if (resp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", int'(resp_valid), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_valid", int'(resp_valid), int'(e.who));
          check("req_ready", int'(last_ready), int'(e.who));
          check("resp_status", int'(resp_status), int'(e.st));
          check("trans_cmd_count", cmd_cnt, int'(e.cmd));
          if (e.cmd) check("trans_target", int'(cmd_tgt), int'(e.tgt));
          if (e.lat != 0) check("latency", cyc - cmd_cyc, int'(e.lat));
          $display("resp who=%b status=%b cmds=%0d", resp_valid, resp_status, cmd_cnt);
        end
        cmd_cnt = 0;
      end
    end
  end

  // LC FSM model: answers trans_cmd after lc_delay cycles (0 = never).
  initial forever begin
    @(negedge clk);
    if (trans_cmd && rst_n && lc_delay > 0) begin
      repeat (lc_delay) @(posedge clk);
      #1 trans_done = 1'b1; trans_ok = lc_ok;
      @(posedge clk);
      #1 trans_done = 1'b0; trans_ok = 1'b0;
    end
  end

  task automatic wait_accept();
    int n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 2'b00 && n < 50);
    if (req_ready == 2'b00) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 100);
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic txn(input logic [1:0] v, input logic [2:0] t0, input logic [2:0] t1,
                     input logic [2:0] cs);
    @(posedge clk); #1;
    req_valid = v; req_target0 = t0; req_target1 = t1; cur_state = cs;
    wait_accept();
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_trans_cmd", int'(trans_cmd), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fail_cnt", int'(fail_cnt), 0);
    check("rst_locked", int'(locked), 0);
    @(negedge clk) rst_n = 1'b1;

    // Legal Raw->TU0, LC done+ok 3 cycles after command
    lc_delay = 3; lc_ok = 1'b1;
    exp_q.push_back('{2'b01, 2'b00, 1'b1, 3'd1, 8'd4});
    txn(2'b01, 3'd1, 3'd0, 3'd0);
    check("fail_cnt_legal", int'(fail_cnt), 0);

    // Illegal from Rma, via requester 1
    exp_q.push_back('{2'b10, 2'b01, 1'b0, 3'd0, 8'd0});
    txn(2'b10, 3'd0, 3'd1, 3'd3);
    check("fail_cnt_illegal", int'(fail_cnt), 1);

    // Simultaneous requests held through two transactions
    lc_delay = 2;
    exp_q.push_back('{2'b01, 2'b00, 1'b1, 3'd2, 8'd3});
    exp_q.push_back('{2'b10, 2'b00, 1'b1, 3'd3, 8'd3});
    @(posedge clk); #1;
    req_valid = 2'b11; req_target0 = 3'd2; req_target1 = 3'd3; cur_state = 3'd1;
    wait_accept();
    @(posedge clk);
    wait_accept();
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle();
    check("fail_cnt_dual", int'(fail_cnt), 1);

    // Timeout: LC never answers
    lc_delay = 0;
    exp_q.push_back('{2'b01, 2'b11, 1'b1, 3'd2, 8'(T + 1)});
    txn(2'b01, 3'd2, 3'd0, 3'd1);
    check("fail_cnt_timeout", int'(fail_cnt), 2);

    // Done on the final timeout cycle wins
    lc_delay = T;
    exp_q.push_back('{2'b01, 2'b00, 1'b1, 3'd2, 8'(T + 1)});
    txn(2'b01, 3'd2, 3'd0, 3'd1);
    check("fail_cnt_tie", int'(fail_cnt), 2);

    // Reset while waiting: no response, outputs cleared at once
    lc_delay = 0;
    @(posedge clk); #1;
    req_valid = 2'b01; req_target0 = 3'd2; cur_state = 3'd1;
    wait_accept();
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("wrst_busy", int'(busy), 0);
    check("wrst_trans_cmd", int'(trans_cmd), 0);
    check("wrst_resp_valid", int'(resp_valid), 0);
    check("wrst_resp_status", int'(resp_status), 0);
    check("wrst_trans_target", int'(trans_target), 0);
    check("wrst_fail_cnt", int'(fail_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lc_delay = 3; lc_ok = 1'b1;
    exp_q.push_back('{2'b01, 2'b00, 1'b1, 3'd1, 8'd4});
    txn(2'b01, 3'd1, 3'd0, 3'd0);

    // Three LC failures lead to lockout
    lc_delay = 1; lc_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{2'b01, 2'b10, 1'b1, 3'd1, 8'd2});
      txn(2'b01, 3'd1, 3'd0, 3'd2);
    end
    check("fail_cnt_lock", int'(fail_cnt), 3);
    @(negedge clk);
    check("locked", int'(locked), 1);
    exp_q.push_back('{2'b01, 2'b01, 1'b0, 3'd0, 8'd0});
    txn(2'b01, 3'd1, 3'd0, 3'd2);
    check("locked_sticky", int'(locked), 1);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1);
  end
endmodule
